// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write arbiter slice.
package fifo_arb_pkg;

    localparam int DEF_N     = 16;
    localparam int DEF_R     = 4;
    localparam int DEF_BURST = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Width of a port index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO-side signals of the write arbiter; the arbiter is the slave.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
    parameter int N = DEF_N,
    parameter int R = DEF_R
) ();

    logic [R-1:0]        req;
    logic [R-1:0][N-1:0] din;
    logic [R-1:0]        gnt;
    logic [R-1:0]        ack;
    logic                fifo_full;
    logic                fifo_half_full;
    logic                fifo_we;
    logic [N-1:0]        fifo_din;
    logic                busy;

    modport master (
        output req, din, fifo_full, fifo_half_full,
        input  gnt, ack, fifo_we, fifo_din, busy
    );

    modport slave (
        input  req, din, fifo_full, fifo_half_full,
        output gnt, ack, fifo_we, fifo_din, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set req bit searching upward from last_owner+1, wrapping.
module rr_picker import fifo_arb_pkg::*; #(
    parameter int R  = DEF_R,
    parameter int LW = idx_width(R)
) (
    input  logic [R-1:0]  req,
    input  logic [LW-1:0] last_owner,
    output logic [R-1:0]  winner,
    output logic          valid
);

    logic [R-1:0] winner_s;
    logic         valid_s;
    logic [LW-1:0] idx_v;

    // Walk the ring once; the first requester found blocks all later ones.
    always_comb begin
        winner_s = {R{1'b0}};
        valid_s  = 1'b0;
        idx_v    = {LW{1'b0}};
        for (int k = 1; k <= R; k++) begin
            idx_v           = LW'((int'(last_owner) + k) % R);
            winner_s[idx_v] = req[idx_v] & ~valid_s;
            valid_s         = valid_s | req[idx_v];
        end
    end

    assign winner = winner_s;
    assign valid  = valid_s;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter funnelling R write requesters into one FIFO port.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int N     = DEF_N,
    parameter int R     = DEF_R,
    parameter int BURST = DEF_BURST
) (
    input logic              clk,
    input logic              rstn,
    fifo_wr_arbiter_if.slave bus
);

    localparam int LW = idx_width(R);
    localparam int BW = $clog2(BURST) + 1;

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [R-1:0]  gnt_r;
    logic [R-1:0]  gnt_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic [BW-1:0] beat_r;
    logic [BW-1:0] beat_nxt_s;
    logic [LW-1:0] last_r;
    logic [LW-1:0] last_nxt_s;

    logic [LW-1:0] owner_idx_s;
    logic [LW-1:0] pick_base_s;
    logic [R-1:0]  pick_onehot_s;
    logic          pick_valid_s;
    logic [R-1:0]  ack_s;
    logic          fifo_we_s;
    logic [N-1:0]  fifo_din_s;
    logic          owner_req_s;
    logic          accept_s;
    logic [BW-1:0] limit_s;
    logic          release_s;

    // Index of the current owner, recovered from the one-hot grant.
    always_comb begin
        owner_idx_s = {LW{1'b0}};
        for (int i = 0; i < R; i++) begin
            owner_idx_s = owner_idx_s | (LW'(i) & {LW{gnt_r[i]}});
        end
    end

    // While owning, a release searches from the owner so it goes to the back of the ring.
    assign pick_base_s = (state_r == OWN) ? owner_idx_s : last_r;

    rr_picker #(
        .R  (R),
        .LW (LW)
    ) u_picker (
        .req        (bus.req),
        .last_owner (pick_base_s),
        .winner     (pick_onehot_s),
        .valid      (pick_valid_s)
    );

    // Output muxing; the reset cycle is gated so an aborted burst writes nothing.
    always_comb begin
        ack_s      = gnt_r & bus.req & {R{~bus.fifo_full & rstn}};
        fifo_we_s  = |ack_s;
        fifo_din_s = {N{1'b0}};
        for (int i = 0; i < R; i++) begin
            fifo_din_s = fifo_din_s | (bus.din[i] & {N{gnt_r[i]}});
        end
    end

    assign owner_req_s = |(gnt_r & bus.req);
    assign accept_s    = fifo_we_s;
    assign limit_s     = bus.fifo_half_full ? BW'(1) : BW'(BURST);
    assign release_s   = ~owner_req_s | (accept_s & ((beat_r + BW'(1)) >= limit_s));

    // Next-state, grant, beat counter and last-owner update.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        beat_nxt_s  = beat_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = OWN;
                    gnt_nxt_s   = pick_onehot_s;
                    beat_nxt_s  = {BW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = {R{1'b0}};
                end
            end
            OWN: begin
                if (release_s) begin
                    beat_nxt_s  = {BW{1'b0}};
                    last_nxt_s  = owner_idx_s;
                    state_nxt_s = pick_valid_s ? OWN : IDLE;
                    gnt_nxt_s   = pick_valid_s ? pick_onehot_s : {R{1'b0}};
                end else if (accept_s) begin
                    beat_nxt_s = beat_r + BW'(1);
                end else begin
                    beat_nxt_s = beat_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = {R{1'b0}};
                beat_nxt_s  = {BW{1'b0}};
            end
        endcase
        busy_nxt_s = |gnt_nxt_s;
    end

    // State register with synchronous active-low reset; port 0 gets first priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
            gnt_r   <= {R{1'b0}};
            busy_r  <= 1'b0;
            beat_r  <= {BW{1'b0}};
            last_r  <= LW'(R - 1);
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            busy_r  <= busy_nxt_s;
            beat_r  <= beat_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.busy     = busy_r;
    assign bus.ack      = ack_s;
    assign bus.fifo_we  = fifo_we_s;
    assign bus.fifo_din = fifo_din_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an owner/beat reference model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 16;
    localparam int R     = 4;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .R(R)) bus ();

    fifo_wr_arbiter #(.N(N), .R(R), .BURST(BURST)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // requester agents: words left to offer, words already written, willingness
    int   avail [R];
    int   sent  [R];
    logic en    [R];

    // reference model: owner (-1 = none), accepted words this grant, last owner
    int m_owner;
    int m_beats;
    int m_last;

    int           cyc;
    logic [31:0]  we_mask;
    logic [R-1:0] gh [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at t=%0t cyc=%0d: observed %0h, expected %0h", tag, $time, cyc, obs, exp_v);
        end
    endtask

    function automatic logic [N-1:0] make_word(input int i, input int s);
        return N'((i * 4096) + ((s * 37 + 11) % 4096));
    endfunction

    function automatic int rr_pick(input int last, input logic [R-1:0] r);
        for (int k = 1; k <= R; k++) begin
            if (r[(last + k) % R]) return (last + k) % R;
        end
        return -1;
    endfunction

    task automatic model_next();
        bit rel;
        rel = 1'b0;
        if (!rstn) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = R - 1;
        end else if (m_owner < 0) begin
            m_owner = rr_pick(m_last, bus.req);
            m_beats = 0;
        end else begin
            if (!bus.req[m_owner]) rel = 1'b1;
            else if (!bus.fifo_full) begin
                m_beats++;
                if (m_beats >= (bus.fifo_half_full ? 1 : BURST)) rel = 1'b1;
            end
            if (rel) begin
                m_last  = m_owner;
                m_beats = 0;
                m_owner = rr_pick(m_last, bus.req);
            end
        end
    endtask

    // one clock: drive requesters, check at negedge, advance model, retire accepted words
    task automatic step();
        logic [R-1:0] egnt;
        logic [R-1:0] eack;
        logic [N-1:0] edin;
        for (int i = 0; i < R; i++) begin
            bus.req[i] = en[i] && (avail[i] > 0);
            bus.din[i] = make_word(i, sent[i]);
        end
        @(negedge clk);
        egnt = {R{1'b0}};
        eack = {R{1'b0}};
        edin = {N{1'b0}};
        if (m_owner >= 0) begin
            egnt[m_owner] = 1'b1;
            edin = make_word(m_owner, sent[m_owner]);
            if (rstn && bus.req[m_owner] && !bus.fifo_full) eack[m_owner] = 1'b1;
        end
        chk("gnt",      32'(bus.gnt),      32'(egnt));
        chk("ack",      32'(bus.ack),      32'(eack));
        chk("fifo_we",  32'(bus.fifo_we),  32'(|eack));
        chk("busy",     32'(bus.busy),     32'(m_owner >= 0));
        chk("fifo_din", 32'(bus.fifo_din), 32'(edin));
        if (cyc < 64) gh[cyc] = bus.gnt;
        if (cyc < 32 && bus.fifo_we) we_mask[cyc] = 1'b1;
        model_next();
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++) begin
            if (eack[i]) begin
                sent[i]++;
                avail[i]--;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.fifo_full      = 1'b0;
        bus.fifo_half_full = 1'b0;
        for (int i = 0; i < R; i++) begin
            en[i]    = 1'b0;
            avail[i] = 0;
            sent[i]  = 0;
        end
        step();
        step();
        rstn    = 1'b1;
        cyc     = 0;
        we_mask = 32'h0;
        for (int i = 0; i < 64; i++) gh[i] = {R{1'b0}};
    endtask

    initial begin
        rstn = 1'b0;
        cyc  = 0;
        bus.req            = {R{1'b0}};
        bus.din            = {(R*N){1'b0}};
        bus.fifo_full      = 1'b0;
        bus.fifo_half_full = 1'b0;
        @(posedge clk);
        #1;
        m_owner = -1;
        m_beats = 0;
        m_last  = R - 1;

        // single requester, six words, re-granted across the burst boundary
        do_reset();
        en[0] = 1'b1;
        avail[0] = 6;
        for (int c = 0; c < 9; c++) step();
        chk("s34_gnt_c1", 32'(gh[1]), 32'h1);
        chk("s34_we_mask", we_mask & 32'h1FF, 32'h7E);
        chk("s34_words", 32'(sent[0]), 32'd6);

        // all four requesting: full bursts in ring order with no gaps
        do_reset();
        for (int i = 0; i < R; i++) begin
            en[i] = 1'b1;
            avail[i] = 8;
        end
        for (int c = 0; c < 21; c++) step();
        for (int b = 0; b < 5; b++) chk("s35_owner", 32'(gh[1 + 4 * b]), 32'(1 << (b % 4)));
        chk("s35_we_mask", we_mask & 32'h1FFFFF, 32'h1FFFFE);
        chk("s35_words0", 32'(sent[0]), 32'd8);
        chk("s35_words3", 32'(sent[3]), 32'd4);

        // owner 2 stalled by fifo_full for three cycles mid-burst
        do_reset();
        en[2] = 1'b1;
        avail[2] = 4;
        for (int c = 0; c < 9; c++) begin
            bus.fifo_full = (c >= 3 && c <= 5);
            step();
        end
        for (int c = 3; c <= 5; c++) chk("s36_hold", 32'(gh[c]), 32'h4);
        chk("s36_we_mask", we_mask & 32'h1FF, 32'hC6);
        chk("s36_words", 32'(sent[2]), 32'd4);

        // half full: one word per grant, alternating owners
        do_reset();
        bus.fifo_half_full = 1'b1;
        en[0] = 1'b1;
        en[1] = 1'b1;
        avail[0] = 4;
        avail[1] = 4;
        for (int c = 0; c < 9; c++) step();
        for (int c = 1; c <= 6; c++) chk("s37_alt", 32'(gh[c]), (c % 2 == 1) ? 32'h1 : 32'h2);
        chk("s37_we_mask", we_mask & 32'h1FF, 32'h1FE);

        // reset during owner 1's second beat aborts the burst
        do_reset();
        en[1] = 1'b1;
        avail[1] = 4;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                rstn = 1'b0;
                en[0] = 1'b1;
                avail[0] = 4;
            end else begin
                rstn = 1'b1;
            end
            step();
        end
        chk("s38_gnt_after_rst", 32'(gh[3]), 32'h0);
        chk("s38_port0_first", 32'(gh[4]), 32'h1);
        chk("s38_we_mask", we_mask & 32'h1F, 32'h12);

        // random traffic, stalls, half-full, withdrawn requests and rare resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < R; i++) begin
                if (avail[i] == 0 && $urandom_range(0, 3) == 0) avail[i] = int'($urandom_range(1, 10));
                en[i] = ($urandom_range(0, 9) != 0);
            end
            bus.fifo_full      = ($urandom_range(0, 4) == 0);
            bus.fifo_half_full = ($urandom_range(0, 3) == 0);
            rstn               = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the data word width and matching the FIFO D_in width.
REQ-002 The block SHALL have parameter R, default 4, meaning the number of write requesters.
REQ-003 The block SHALL have parameter BURST, default 4, meaning the maximum words accepted per grant.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rstn: input, 1 bit, synchronous active-low reset, sampled on rising clk.
REQ-006 Port req: input, R bits, requester i holds req[i]=1 while it has a word on din[i].
REQ-007 Port din: input, R x N bits, packed per-requester write data.
REQ-008 Port gnt: output, R bits, registered one-hot current owner, or all-zero when no owner.
REQ-009 Port ack: output, R bits, combinational one-hot; ack[i]=1 means din[i] is written this cycle.
REQ-010 Port fifo_full: input, 1 bit, the FIFO full flag.
REQ-011 Port fifo_half_full: input, 1 bit, the FIFO half_full flag.
REQ-012 Port fifo_we: output, 1 bit, combinational FIFO write enable.
REQ-013 Port fifo_din: output, N bits, combinational FIFO write data.
REQ-014 Port busy: output, 1 bit, registered; 1 whenever gnt is non-zero.

Function
REQ-015 The controller SHALL have exactly two states: IDLE (gnt=0) and OWN (gnt one-hot).
REQ-016 ack[i] SHALL equal gnt[i] & req[i] & ~fifo_full.
REQ-017 fifo_we SHALL equal |ack, and fifo_din SHALL equal din of the granted port, or 0 when gnt=0.
REQ-018 Grant latency SHALL be one cycle: a req seen in IDLE gives gnt on the next edge, and no word is accepted in the cycle req first rises from IDLE.
REQ-019 Arbitration SHALL be round-robin: the search starts at (last_owner+1) mod R, and the first set req bit wins.
REQ-020 In OWN, a beat counter (width clog2(BURST)+1) SHALL increment on every ack and hold while fifo_full stalls it.
REQ-021 The burst limit SHALL be BURST when fifo_half_full=0 and 1 when fifo_half_full=1, sampled on each accepting cycle.
REQ-022 Release SHALL occur at the edge after the accept that reaches the limit, or at the edge where the owner's req=0.
REQ-023 On release, if any other req is pending (the old owner included), the next owner SHALL be granted at the same edge with no idle bubble; otherwise the state SHALL go to IDLE.
REQ-024 On release, the beat counter SHALL clear to 0, and last_owner SHALL be set to the released port.
REQ-025 With fifo_full=1, gnt SHALL hold, ack and fifo_we SHALL be 0, and there is no timeout.
REQ-026 An owner that drops req before any accept SHALL be released with zero words written.
REQ-027 A single active requester SHALL be re-granted back-to-back, accepting one word per cycle across burst boundaries.
REQ-028 fifo_we SHALL never assert while fifo_full=1 in the same cycle, so overwrites are impossible.

Reset
REQ-029 When rstn=0 at a rising edge, the block SHALL set state=IDLE, gnt=0, busy=0, beat=0 and last_owner=R-1, so port 0 has first priority.
REQ-030 A reset asserted mid-burst SHALL abort the burst; ack and fifo_we SHALL be 0 in the reset cycle regardless of req, and no word is written.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum typedef (IDLE, OWN) and the default constants for N, R and BURST.
REQ-032 A combinational sub-module rr_picker SHALL take (req, last_owner) and return a one-hot winner plus a valid flag.
REQ-033 The top level SHALL contain only the FSM, the beat counter, the last_owner register and the output muxing.

Verification
REQ-034 Reset, then req=4'b0001 held and 6 words presented -> gnt=0001 at cycle 1, fifo_we high for cycles 1-4, a 1-cycle re-grant gap-free, and all 6 words written in order.
REQ-035 req=4'b1111 held, all flags 0 -> owners 0,1,2,3,0 in turn, each writing exactly 4 words, with no cycle where fifo_we=0.
REQ-036 Owner 2 mid-burst after 2 words, then fifo_full=1 for 3 cycles -> gnt stays 0100, ack=0, and the remaining 2 words are written once fifo_full drops.
REQ-037 fifo_half_full=1 and req=4'b0011 -> gnt alternates 0001/0010 every cycle, one word per grant.
REQ-038 rstn=0 during owner 1's second beat -> the next cycle shows gnt=0, fifo_we=0, and after release port 0 wins first.
